hack_video_scanout: RTL and testbench



---
 rtl/hack_video_scanout.sv | 193 +++++++++++++++++++
 tb/tb_hack_video_scanout.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_video_scanout.sv
// rtl/hack_video_scanout.sv - raster timing and 1 bpp screen-RAM scanout for the Hack core
//
// Generates pixel enable, blank and sync timing for a configurable raster. It fetches
// screen-RAM words for a centred window and serialises them into 8-bit luma.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   ce_pix    one-clk pulse every CE_DIV clks; high in the clk right after outputs change
//   HBlank    horizontal blank
//   HSync     horizontal sync, active level SYNC_POL
//   VBlank    vertical blank
//   VSync     vertical sync, active level SYNC_POL
//   video     8-bit pixel luma
//   ram_addr  screen-RAM word address, held between strobes
//   ram_rd    one-clk read strobe
//   ram_q     screen-RAM read data, valid exactly 1 clk after ram_rd
//   invert    (only with HACK_VIDEO_INVERT_EN) complements window luma
//
// Optional feature macro: HACK_VIDEO_INVERT_EN
module hack_video_scanout #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter int         CE_DIV   = 2,
  parameter int         SCR_W    = 512,
  parameter int         SCR_H    = 256,
  parameter int         WORD_W   = 16,
  parameter int         ADDR_W   = 13,
  parameter int         X_OFS    = 64,
  parameter int         Y_OFS    = 112,
  parameter logic       SYNC_POL = 1'b0,
  parameter logic [7:0] BORDER   = 8'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              ce_pix,
  output logic              HBlank,
  output logic              HSync,
  output logic              VBlank,
  output logic              VSync,
  output logic [7:0]        video,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [WORD_W-1:0] ram_q
`ifdef HACK_VIDEO_INVERT_EN
  ,
  input  logic              invert
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CE_DIV);
  localparam int WPL     = SCR_W / WORD_W;

  logic [DW-1:0]     div;
  logic              ce;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic              h_last;
  logic              v_last;
  logic              rd_d;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] shift;

  logic [31:0]       hx;
  logic [31:0]       vy;
  logic [31:0]       col;
  logic [31:0]       row;
  logic [31:0]       fcol;
  logic              h_act;
  logic              v_act;
  logic              row_in;
  logic              in_win;
  logic              hs_on;
  logic              vs_on;
  logic              word_start;
  logic              fetch;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WORD_W-1:0] word_src;
  logic [WORD_W-1:0] pix_word;
  logic              pix_bit;
  logic              inv;

`ifdef HACK_VIDEO_INVERT_EN
  assign inv = invert;
`else
  assign inv = 1'b0;
`endif

  // Internal pixel enable; the ce_pix port is this delayed by one clk so it
  // coincides with the clk in which the freshly registered pixel is presented.
  assign ce     = (div == DW'(CE_DIV - 1));
  assign h_last = (hcnt == HW'(H_TOTAL - 1));
  assign v_last = (vcnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (ce) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce) begin
      hcnt <= h_last ? '0 : hcnt + HW'(1);
      if (h_last) begin
        vcnt <= v_last ? '0 : vcnt + VW'(1);
      end
    end
  end

  // Position decode. Window offsets use unsigned wrap so positions left of
  // or above the window become huge and fail the range compare.
  always_comb begin
    hx         = 32'(hcnt);
    vy         = 32'(vcnt);
    col        = hx - 32'(X_OFS);
    row        = vy - 32'(Y_OFS);
    fcol       = hx + 32'd1 - 32'(X_OFS);
    h_act      = (hx < 32'(H_ACTIVE));
    v_act      = (vy < 32'(V_ACTIVE));
    row_in     = (row < 32'(SCR_H));
    in_win     = h_act && v_act && row_in && (col < 32'(SCR_W));
    hs_on      = (hx >= 32'(H_ACTIVE + H_FP)) && (hx < 32'(H_ACTIVE + H_FP + H_SYNC));
    vs_on      = (vy >= 32'(V_ACTIVE + V_FP)) && (vy < 32'(V_ACTIVE + V_FP + V_SYNC));
    word_start = in_win && ((col % 32'(WORD_W)) == 32'd0);
    // Fetch one pixel ahead of each word boundary so the data lands in time.
    fetch      = ce && h_act && v_act && row_in && (fcol < 32'(SCR_W))
                 && ((fcol % 32'(WORD_W)) == 32'd0);
    fetch_addr = ADDR_W'(row * 32'(WPL) + fcol / 32'(WORD_W));
    // With CE_DIV = 2 the read data arrives on the same clk as the word's
    // first pixel, so bypass the holding register while it is being loaded.
    word_src   = rd_d ? ram_q : hold;
    pix_word   = word_start ? word_src : shift;
    pix_bit    = pix_word[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_pix   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      rd_d     <= 1'b0;
      hold     <= '0;
      shift    <= '0;
      video    <= 8'h00;
      HBlank   <= 1'b1;
      VBlank   <= 1'b1;
      HSync    <= ~SYNC_POL;
      VSync    <= ~SYNC_POL;
    end else begin
      ce_pix <= ce;
      ram_rd <= fetch;
      rd_d   <= ram_rd;
      if (rd_d) begin
        hold <= ram_q;
      end
      if (fetch) begin
        ram_addr <= fetch_addr;
      end
      if (ce) begin
        HBlank <= !h_act;
        VBlank <= !v_act;
        HSync  <= hs_on ? SYNC_POL : ~SYNC_POL;
        VSync  <= vs_on ? SYNC_POL : ~SYNC_POL;
        shift  <= pix_word >> 1;
        if (!h_act || !v_act) begin
          video <= 8'h00;
        end else if (in_win) begin
          video <= (pix_bit ^ inv) ? 8'h00 : 8'hFF;
        end else begin
          video <= BORDER;
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_video_scanout.sv
// tb/tb_hack_video_scanout.sv - directed self-checking bench for hack_video_scanout
//
// Runs a reduced raster: 120 x 48 total, 96 x 40 active, 64 x 16 window at (16,12).
// Optional feature macro: HACK_VIDEO_INVERT_EN
module tb_hack_video_scanout;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_pix;
  logic        HBlank;
  logic        HSync;
  logic        VBlank;
  logic        VSync;
  logic [7:0]  video;
  logic [5:0]  ram_addr;
  logic        ram_rd;
  logic [15:0] ram_q = 16'h0000;
`ifdef HACK_VIDEO_INVERT_EN
  logic        invert;
`endif

  logic [15:0] mem [64];

  int n_chk = 0;
  int n_pass = 0;
  int tb_h, tb_v, frame, ce_idx;
  int inv_mode;
  int err_video, err_hs, err_vs, err_blank, err_rd, err_ce;
  int line_hs, line_rd, strobes, line12_rd, first13, last_addr, vs_lines;
  int hs_fall, vs_fall, hs_checked;
  logic prev_hs, prev_vs;

  hack_video_scanout #(
    .H_ACTIVE(96), .H_FP(4), .H_SYNC(8), .H_BP(12),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CE_DIV(2), .SCR_W(64), .SCR_H(16), .WORD_W(16), .ADDR_W(6),
    .X_OFS(16), .Y_OFS(12), .SYNC_POL(1'b0), .BORDER(8'h20)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce_pix   (ce_pix),
    .HBlank   (HBlank),
    .HSync    (HSync),
    .VBlank   (VBlank),
    .VSync    (VSync),
    .video    (video),
    .ram_addr (ram_addr),
    .ram_rd   (ram_rd),
    .ram_q    (ram_q)
`ifdef HACK_VIDEO_INVERT_EN
    ,
    .invert   (invert)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_video(input int h, input int v);
    if (h >= 96 || v >= 40) return 8'h00;
    if (h < 16 || h >= 80 || v < 12 || v >= 28) return 8'h20;
    if (inv_mode != 0) return 8'hFF;
    return (v == 12 && h == 16) ? 8'h00 : 8'hFF;
  endfunction

  task automatic restart();
    tb_h = 0; tb_v = 0; frame = 0; ce_idx = 0;
    line_hs = 0; line_rd = 0; strobes = 0; line12_rd = 0;
    first13 = -1; last_addr = -1; vs_lines = 0;
    hs_fall = -1; vs_fall = -1; hs_checked = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  task automatic next_ce(output int clks);
    clks = 0;
    do begin
      @(negedge clk);
      clks++;
      if (!ce_pix && ram_rd) err_rd++;
      if (clks > 8) begin
        $display("FAIL ce_timeout: got no ce_pix in %0d clks expected one", clks);
        $fatal(1, "no pixel enable");
      end
    end while (!ce_pix);
  endtask

  task automatic pixel(output int clks);
    logic es;
    int   ea;
    next_ce(clks);
    if (clks != 2) err_ce++;
    if (video !== exp_video(tb_h, tb_v)) err_video++;
    if (HSync !== !(tb_h >= 100 && tb_h < 108)) err_hs++;
    if (VSync !== !(tb_v >= 42 && tb_v < 44)) err_vs++;
    if (HBlank !== (tb_h >= 96) || VBlank !== (tb_v >= 40)) err_blank++;
    es = (tb_v >= 12 && tb_v < 28 && tb_h >= 15 && tb_h <= 63 && ((tb_h - 15) % 16) == 0);
    ea = (tb_v - 12) * 4 + (tb_h - 15) / 16;
    if (ram_rd !== es) err_rd++;
    else if (ram_rd && int'(ram_addr) != ea) err_rd++;
    if (ram_rd) begin
      strobes++; line_rd++; last_addr = int'(ram_addr);
      if (tb_v == 12) line12_rd++;
      if (tb_v == 13 && first13 < 0) first13 = int'(ram_addr);
    end
    if (!HSync) line_hs++;
    if (tb_h == 0 && !VSync) vs_lines++;
    if (prev_hs && !HSync) begin
      if (hs_fall < 0) check("hs_first_pos", tb_h, 100);
      else if (hs_checked == 0) begin check("hs_period", ce_idx - hs_fall, 120); hs_checked = 1; end
      hs_fall = ce_idx;
    end
    if (prev_vs && !VSync) begin
      if (vs_fall < 0) check("vs_first_pos", tb_v * 1000 + tb_h, 42000);
      else check("vs_period", ce_idx - vs_fall, 5760);
      vs_fall = ce_idx;
    end
    prev_hs = HSync; prev_vs = VSync;
    if (frame == 0 && inv_mode == 0) begin
      if (tb_v == 12 && tb_h == 16) check("px_12_16_black", video, 8'h00);
      if (tb_v == 12 && tb_h == 17) check("px_12_17_white", video, 8'hFF);
      if (tb_v == 12 && tb_h == 31) check("px_12_31_white", video, 8'hFF);
      if (tb_v == 12 && tb_h == 15) check("px_left_border", video, 8'h20);
      if (tb_v == 12 && tb_h == 15) check("rd_first_pos", ram_rd, 1'b1);
      if (tb_v == 12 && tb_h == 80) check("px_right_border", video, 8'h20);
      if (tb_v == 11 && tb_h == 40) check("px_top_border", video, 8'h20);
      if (tb_v == 20 && tb_h == 100) check("px_hblank", video, 8'h00);
      if (tb_v == 44 && tb_h == 40) check("px_vblank", video, 8'h00);
    end
    if (inv_mode != 0 && tb_v == 13 && tb_h == 20) check("px_inv_window", video, 8'hFF);
    if (inv_mode != 0 && tb_v == 13 && tb_h == 10) check("px_inv_border", video, 8'h20);
    ce_idx++;
    tb_h++;
    if (tb_h == 120) begin
      if (frame == 0 && tb_v < 2) check("hsync_width", line_hs, 8);
      if (frame == 0 && tb_v == 0) check("line0_no_rd", line_rd, 0);
      line_hs = 0; line_rd = 0; tb_h = 0; tb_v++;
      if (tb_v == 48) begin
        if (frame == 0) begin
          check("strobes_frame", strobes, 64);
          check("vsync_lines", vs_lines, 2);
          check("line12_strobes", line12_rd, 4);
          check("line13_first_addr", first13, 4);
          check("last_addr", last_addr, 63);
        end
        strobes = 0; vs_lines = 0; tb_v = 0; frame++;
      end
    end
  endtask

  task automatic check_errs(input string sfx);
    check({"err_video", sfx}, err_video, 0);
    check({"err_hsync", sfx}, err_hs, 0);
    check({"err_vsync", sfx}, err_vs, 0);
    check({"err_blank", sfx}, err_blank, 0);
    check({"err_ram_rd", sfx}, err_rd, 0);
    check({"err_ce_period", sfx}, err_ce, 0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    inv_mode = 0;
    err_video = 0; err_hs = 0; err_vs = 0; err_blank = 0; err_rd = 0; err_ce = 0;
`ifdef HACK_VIDEO_INVERT_EN
    invert = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {ce_pix, ram_rd, HBlank, VBlank, HSync, VSync}, 6'b001111);
    check("rst_video", video, 8'h00);
    check("rst_addr", ram_addr, 6'd0);

    restart();
    reset_n = 1'b1;
    pixel(c);
    check("first_ce_clks", c, 2);
    while (frame < 2) pixel(c);
    check_errs("_2frames");

    while (!(tb_v == 20 && tb_h == 50)) pixel(c);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_ctl", {ce_pix, ram_rd, HBlank, VBlank, HSync, VSync}, 6'b001111);
    check("midrst_video", video, 8'h00);
    check("midrst_addr", ram_addr, 6'd0);
    repeat (3) @(negedge clk);
    restart();
    reset_n = 1'b1;
    pixel(c);
    check("midrst_first_ce_clks", c, 2);
    while (frame < 1) pixel(c);

`ifdef HACK_VIDEO_INVERT_EN
    for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
    invert = 1'b1;
    inv_mode = 1;
    while (frame < 2) pixel(c);
`endif

    check_errs("_final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
